// File: rtl/piso_pkg.sv
// Shared types for the parallel-in serial-out serializer.
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } piso_state_t;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: captures a word on load and streams it out
// one bit per valid/ready transfer, pulsing done after the last bit is taken.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  out_ready,
    output logic                  sout,
    output logic                  sout_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CNT_W   = $clog2(DATA_WIDTH + 1);
    localparam int unsigned OUT_IDX = MSB_FIRST ? DATA_WIDTH - 1 : 0;

    piso_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d = d;
                    cnt_d   = CNT_W'(DATA_WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // sout_valid is high throughout SHIFT, so out_ready alone marks a transfer.
                if (out_ready) begin
                    shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Outputs depend only on flops, so out_ready and load never reach them combinationally.
    assign busy       = (state_q == SHIFT);
    assign sout_valid = busy;
    assign sout       = busy & shreg_q[OUT_IDX];
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and are
// compared each cycle against a bit-queue model of the serial stream.
module tb_piso_serializer;

    logic        clk;
    logic        rst;
    logic        load;
    logic [31:0] d;
    logic        out_ready;
    logic        sout_m, sout_valid_m, busy_m, done_m;
    logic        sout_l, sout_valid_l, busy_l, done_l;

    int total = 0;
    int bad   = 0;

    bit   q_m[$];
    bit   q_l[$];
    logic exp_done = 1'b0;

    piso_serializer #(.DATA_WIDTH(32), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .d          (d),
        .out_ready  (out_ready),
        .sout       (sout_m),
        .sout_valid (sout_valid_m),
        .busy       (busy_m),
        .done       (done_m)
    );

    piso_serializer #(.DATA_WIDTH(32), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .d          (d),
        .out_ready  (out_ready),
        .sout       (sout_l),
        .sout_valid (sout_valid_l),
        .busy       (busy_l),
        .done       (done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare both instances against the model, then advance model and clock one cycle.
    task automatic step();
        logic exp_busy;
        exp_busy = (q_m.size() != 0);
        chk("busy_m", busy_m, exp_busy);
        chk("valid_m", sout_valid_m, exp_busy);
        chk("sout_m", sout_m, exp_busy ? logic'(q_m[0]) : 1'b0);
        chk("done_m", done_m, exp_done);
        chk("busy_l", busy_l, exp_busy);
        chk("valid_l", sout_valid_l, exp_busy);
        chk("sout_l", sout_l, exp_busy ? logic'(q_l[0]) : 1'b0);
        chk("done_l", done_l, exp_done);

        if (rst) begin
            q_m.delete();
            q_l.delete();
            exp_done = 1'b0;
        end else if (q_m.size() != 0) begin
            exp_done = 1'b0;
            if (out_ready) begin
                q_m.delete(0);
                q_l.delete(0);
                exp_done = (q_m.size() == 0);
            end
        end else begin
            exp_done = 1'b0;
            if (load) begin
                for (int i = 0; i < 32; i++) begin
                    q_m.push_back(d[31-i]);
                    q_l.push_back(d[i]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] word;

        rst = 1'b1; load = 1'b0; d = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
        end

        // MSB-first stream with out_ready held high.
        word = 32'hA5A5_0F0F;
        d = word; load = 1'b1; out_ready = 1'b1;
        step();
        load = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            if (k <= 32) chk("msb_bit", sout_m, word[32-k]);
            chk("msb_done_cycle", done_m, logic'(k == 33));
            step();
        end

        // Backpressure on cycles 3..7, then done 5 cycles late.
        d = word; load = 1'b1; out_ready = 1'b1;
        step();
        load = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            out_ready = !(k >= 3 && k <= 7);
            if (k >= 3 && k <= 8) chk("bp_frozen_bit", sout_m, 1'b1);
            chk("bp_done_cycle", done_m, logic'(k == 38));
            step();
        end

        // Load while busy at cycle 10 must be ignored.
        d = word; load = 1'b1; out_ready = 1'b1;
        step();
        load = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            load = (k == 10);
            d    = (k == 10) ? 32'hFFFF_FFFF : word;
            if (k <= 32) chk("busy_load_bit", sout_m, word[32-k]);
            step();
        end
        load = 1'b0;

        // Reset mid-shift at cycle 12, fresh load at cycle 15.
        d = word; load = 1'b1; out_ready = 1'b1;
        step();
        load = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            rst  = (k == 12);
            load = (k == 15);
            d    = 32'h1234_5678;
            if (k == 13) chk("abort_busy", busy_m, 1'b0);
            if (k >= 13 && k <= 15) chk("abort_no_done", done_m, 1'b0);
            step();
        end
        rst = 1'b0; load = 1'b0;

        // LSB-first with back-to-back word loaded in the done cycle.
        d = 32'h0000_0001; load = 1'b1; out_ready = 1'b1;
        step();
        load = 1'b0;
        for (int k = 1; k <= 67; k++) begin
            load = (k == 33);
            d    = 32'h8000_0000;
            if (k == 1) chk("lsb_first_one", sout_l, 1'b1);
            if (k == 33) chk("b2b_done1", done_l, 1'b1);
            if (k == 64) chk("b2b_zero_before_last", sout_l, 1'b0);
            if (k == 65) chk("b2b_last_one", sout_l, 1'b1);
            if (k == 66) chk("b2b_done2", done_l, 1'b1);
            step();
        end
        load = 1'b0;

        // Randomized traffic, backpressure and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            load      = ($urandom_range(0, 3) == 0);
            d         = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0; load = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 40; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out reader for 32-bit register words. It captures a parallel word on a load request and shifts it out one bit per accepted transfer on a valid/ready serial interface. On completion it reports a one-cycle done pulse. It sits downstream of the team's data registers and converts register contents into a bitstream for a serial link or a debug port.

Parameters:
DATA_WIDTH, 32, word width in bits; legal range is DATA_WIDTH >= 2.
MSB_FIRST, 1, 1 shifts d[DATA_WIDTH-1] out first; 0 shifts d[0] out first.

Ports:
clk  input  1  system clock; all logic is clocked on the rising edge.
rst  input  1  synchronous, active-high reset.
load  input  1  request to capture d; honoured only when busy=0.
d  input  DATA_WIDTH  parallel word; sampled only on an accepted load.
out_ready  input  1  downstream accepts sout this cycle.
sout  output  1  current serial bit.
sout_valid  output  1  sout holds a valid bit.
busy  output  1  high while a word is being shifted out.
done  output  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- Interface (already decided): one clock (clk). Reset rst is synchronous and active-high. rst takes priority over every other input.
- Reset values: state=IDLE, shift register=0, bit counter=0, sout=0, sout_valid=0, busy=0, done=0.
- FSM states: IDLE and SHIFT. busy=1 exactly when state=SHIFT. sout_valid equals busy.
- Counter: localparam CNT_W = $clog2(DATA_WIDTH+1). It holds the number of bits remaining.
- IDLE behaviour:
  - sout_valid=0 and sout=0.
  - If load=1, capture d into the shift register, set cnt=DATA_WIDTH, and go to SHIFT on the next edge.
- SHIFT behaviour:
  - sout = shreg[DATA_WIDTH-1] when MSB_FIRST=1, and shreg[0] when MSB_FIRST=0.
  - A transfer occurs when sout_valid and out_ready are both high.
  - On a transfer, shift toward the output end with zero fill and decrement cnt.
  - If cnt==1 at the transfer, go to IDLE and assert done on the next cycle.
- Backpressure: while out_ready=0, sout, sout_valid, shreg and cnt hold. There is no timeout.
- Latency with out_ready held at 1:
  - Load accepted at cycle 0.
  - Bit k is valid at cycle k+1 (k = 0..DATA_WIDTH-1).
  - done=1 and busy=0 at cycle DATA_WIDTH+1.
- Back-to-back loads: a load in the cycle where done=1 is accepted. This gives one idle bubble between words.
- Load while busy: ignored. The shift register, counter and d sampling are unaffected. No error flag is raised.
- done: registered, high for exactly one cycle per completed word. It never asserts for an aborted word.
- Reset mid-shift: the word is aborted and all outputs return to their reset values on the next edge. No done pulse is produced.
- rst and load asserted in the same cycle: reset wins and the load is dropped.
- sout is a registered or state-derived value, so there is no combinational path from out_ready or load to any output.

Decomposition:
- Package piso_pkg:
  - typedef enum logic [0:0] {IDLE, SHIFT} piso_state_t.
  - No width constants, because widths depend on parameters.
- CNT_W and the output bit index are module localparams.
- Single flat module; a sub-module is not warranted at this size.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 → sout=0, sout_valid=0, busy=0, done=0 at every cycle until a load.
- MSB-first stream: d=32'hA5A5_0F0F, load for 1 cycle, out_ready=1 → sout sequence 1010_0101_1010_0101_0000_1111_0000_1111 on cycles 1..32; done=1 only on cycle 33.
- Backpressure: same word, out_ready=0 on cycles 3–7 → sout frozen at bit index 2 (value 1) throughout; stream resumes intact; done arrives 5 cycles later (cycle 38).
- Load while busy: load d=32'hFFFF_FFFF at cycle 10 during the A5A5_0F0F stream → output stream is unchanged; the 32'hFFFF_FFFF word is never emitted.
- Reset mid-shift: rst=1 at cycle 12 → from cycle 13, busy=0, sout_valid=0, sout=0; no done pulse; a fresh load at cycle 15 streams correctly.
- LSB-first and back-to-back (MSB_FIRST=0):
  - d=32'h0000_0001, out_ready=1 → sout=1 at cycle 1, then 0 for 31 cycles.
  - A second load of 32'h8000_0000 in the done cycle (33) → 31 zeros, then a 1 on cycle 65, and done on cycle 66.
